// File: rtl/logic_analyzer_pkg.sv
// Shared definitions for the logic analyzer: capture dump states and the
// sizing defaults common to the sampler and the dumper.
package logic_analyzer_pkg;

    localparam int          ADDR_W_DEF    = 11;
    localparam int          DATA_W_DEF    = 16;
    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_POST,
        ST_SYNC,
        ST_FETCH,
        ST_WAIT,
        ST_SEND,
        ST_FIN
    } dump_state_t;

endpackage

// File: rtl/byte_serializer.sv
// Holds one sample word and hands it out MSB byte first, one byte per
// accepted transfer; 'last' flags that the byte on byte_out is the final one.
module byte_serializer #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] word,
    input  logic              advance,
    output logic [7:0]        byte_out,
    output logic              last
);

    localparam int NBYTES = DATA_W / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NBYTES - 1);

    logic [DATA_W-1:0] shift_q;
    logic [IDX_W-1:0]  idx_q;

    // The current byte always sits in the top lane; accepting one shifts the next up.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (load) begin
            shift_q <= word;
            idx_q   <= IDX_TOP;
        end else if (advance && idx_q != '0) begin
            shift_q <= shift_q << 8;
            idx_q   <= idx_q - 1'b1;
        end
    end

    assign byte_out = shift_q[DATA_W-1 -: 8];
    assign last     = (idx_q == '0);

endmodule

// File: rtl/capture_dumper.sv
// Counts post-trigger sampler writes, freezes the sampler, then streams the
// whole circular sample RAM (oldest word first) as bytes behind a sync byte.
module capture_dumper
    import logic_analyzer_pkg::*;
#(
    parameter int         ADDR_W       = ADDR_W_DEF,
    parameter int         DATA_W       = DATA_W_DEF,
    parameter int         POST_SAMPLES = 1024,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              trigger,
    input  logic              wren,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic              freeze,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] POST_TGT  = ADDR_W'(POST_SAMPLES);
    localparam logic [ADDR_W:0]   LAST_WORD = {1'b0, {ADDR_W{1'b1}}};

    dump_state_t       state, state_next;
    logic [ADDR_W-1:0] post_cnt;
    logic [ADDR_W-1:0] post_cnt_inc;
    logic [ADDR_W-1:0] oldest;
    logic [ADDR_W:0]   word_cnt;
    logic              freeze_q;
    logic              wr_ok;
    logic              post_hit;
    logic              inc_word;
    logic              ser_load;
    logic              ser_advance;
    logic [7:0]        ser_byte;
    logic              ser_last;

    assign wr_ok        = wren && !freeze_q;
    assign post_cnt_inc = post_cnt + 1'b1;

    byte_serializer #(.DATA_W(DATA_W)) u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (ser_load),
        .word     (rd_data),
        .advance  (ser_advance),
        .byte_out (ser_byte),
        .last     (ser_last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // post_hit marks the write that completes the post-trigger window.
    always_comb begin
        state_next  = state;
        post_hit    = 1'b0;
        inc_word    = 1'b0;
        ser_load    = 1'b0;
        ser_advance = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        done        = 1'b0;
        busy        = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (trigger) begin
                    if (POST_SAMPLES == 0 || (POST_SAMPLES == 1 && wren)) begin
                        post_hit   = 1'b1;
                        state_next = ST_SYNC;
                    end else begin
                        state_next = ST_POST;
                    end
                end
            end
            ST_POST: begin
                if (wr_ok && post_cnt_inc == POST_TGT) begin
                    post_hit   = 1'b1;
                    state_next = ST_SYNC;
                end
            end
            ST_SYNC: begin
                tx_valid = 1'b1;
                tx_data  = SYNC_BYTE;
                if (tx_ready) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                ser_load   = 1'b1;
                state_next = ST_SEND;
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                tx_data  = ser_byte;
                if (tx_ready) begin
                    ser_advance = 1'b1;
                    if (ser_last) begin
                        inc_word   = 1'b1;
                        state_next = (word_cnt == LAST_WORD) ? ST_FIN : ST_FETCH;
                    end
                end
            end
            ST_FIN: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The completing write is the newest sample, so the word after it is the oldest.
    always_ff @(posedge clk) begin
        if (!rst) begin
            post_cnt <= '0;
            oldest   <= '0;
            word_cnt <= '0;
            freeze_q <= 1'b0;
        end else begin
            if (state == ST_ARMED && trigger) begin
                post_cnt <= wren ? ADDR_W'(1) : '0;
            end else if (state == ST_POST && wr_ok) begin
                post_cnt <= post_cnt_inc;
            end
            if (post_hit) begin
                oldest   <= wr_addr + 1'b1;
                word_cnt <= '0;
                freeze_q <= 1'b1;
            end else if (inc_word) begin
                word_cnt <= word_cnt + 1'b1;
            end
            if (state == ST_SEND && state_next == ST_FIN) begin
                freeze_q <= 1'b0;
            end
        end
    end

    assign freeze  = freeze_q;
    assign rd_addr = oldest + word_cnt[ADDR_W-1:0];

endmodule

// File: tb/tb_capture_dumper.sv
// Self-checking bench for capture_dumper: a 2048x16 RAM model feeds the
// default build, a 16-word RAM feeds a POST_SAMPLES=0 build; bytes are scoreboarded.
module tb_capture_dumper;
    import logic_analyzer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        start = 1'b0, trigger = 1'b0, wren = 1'b0, tx_ready = 1'b1;
    logic [10:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [10:0] rd_addr;
    logic [15:0] rd_data = '0;
    logic        freeze, tx_valid, busy, done;
    logic [7:0]  tx_data;
    logic [15:0] mem [2048];

    logic        start_b = 1'b0, trigger_b = 1'b0, wren_b = 1'b0, tx_ready_b = 1'b1;
    logic [3:0]  wr_addr_b = '0;
    logic [15:0] wr_data_b = '0;
    logic [3:0]  rd_addr_b;
    logic [15:0] rd_data_b = '0;
    logic        freeze_b, tx_valid_b, busy_b, done_b;
    logic [7:0]  tx_data_b;
    logic [15:0] mem_b [16];

    logic [7:0]  exp_q [$];
    logic [7:0]  exp_b [$];
    int          check_count = 0;
    int          fail_count  = 0;
    int          byte_cnt    = 0;
    int          done_cnt    = 0;
    int          done_cnt_b  = 0;
    bit          rand_ready  = 1'b0;
    bit          stall_a     = 1'b0;
    logic [7:0]  held_a      = '0;

    capture_dumper dut (
        .clk(clk), .rst(rst), .start(start), .trigger(trigger), .wren(wren),
        .wr_addr(wr_addr), .freeze(freeze), .rd_addr(rd_addr), .rd_data(rd_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    capture_dumper #(.ADDR_W(4), .DATA_W(16), .POST_SAMPLES(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .trigger(trigger_b), .wren(wren_b),
        .wr_addr(wr_addr_b), .freeze(freeze_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    // Sampler RAM models: writes blocked while frozen, registered 1-cycle reads.
    always @(posedge clk) begin
        if (wren && !freeze) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
        if (wren_b && !freeze_b) mem_b[wr_addr_b] <= wr_data_b;
        rd_data_b <= mem_b[rd_addr_b];
    end

    initial begin
        forever begin
            @(posedge clk);
            #1 tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard pop on every accepted byte; a stalled byte must not move.
    always @(negedge clk) begin
        if (!rst) begin
            stall_a = 1'b0;
        end else begin
            if (stall_a) begin
                checkOutput("hold_valid", 32'(tx_valid), 32'd1);
                checkOutput("hold_data", 32'(tx_data), 32'(held_a));
            end
            if (done) begin
                done_cnt++;
                checkOutput("freeze_at_done", 32'(freeze), 32'd0);
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) checkOutput("byte_unexpected", 32'(exp_q.size()), 32'd1);
                else checkOutput("byte", 32'(tx_data), 32'(exp_q.pop_front()));
                byte_cnt++;
            end
            stall_a = tx_valid && !tx_ready;
            held_a  = tx_data;
            if (tx_valid_b && tx_ready_b) begin
                if (exp_b.size() == 0) checkOutput("b_byte_unexpected", 32'(exp_b.size()), 32'd1);
                else checkOutput("b_byte", 32'(tx_data_b), 32'(exp_b.pop_front()));
            end
            if (done_b) done_cnt_b++;
        end
    end

    task automatic pushExpected(input logic [10:0] last_addr);
        logic [10:0] a;
        logic [15:0] w;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 2048; i++) begin
            a = last_addr + 11'd1 + 11'(i);
            w = {5'b0, a} ^ 16'h5A5A;
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
        end
    endtask

    // Arm, trigger at trig (no write that cycle), then 1024 post writes.
    task automatic applyStimulus(input int trig, input bit second_trig);
        logic [10:0] a;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        checkOutput("busy_armed", 32'(busy), 32'd1);
        trigger = 1'b1; wren = 1'b0; wr_addr = 11'(trig);
        @(posedge clk); #1 trigger = 1'b0;
        for (int k = 1; k <= 1024; k++) begin
            a = 11'(trig + k);
            wr_addr = a; wr_data = {5'b0, a} ^ 16'h5A5A; wren = 1'b1;
            trigger = second_trig && (k == 10);
            if (k == 1024) begin
                checkOutput("freeze_before_last", 32'(freeze), 32'd0);
                pushExpected(a);
            end
            @(posedge clk); #1;
        end
        wren = 1'b0; trigger = 1'b0;
        checkOutput("freeze_after_last", 32'(freeze), 32'd1);
    endtask

    task automatic waitDone(input string tag);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < 30000) begin
            @(posedge clk); #1 n++;
        end
        repeat (4) @(posedge clk);
        #1;
        checkOutput({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
        checkOutput({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        checkOutput({tag, "_busy_after"}, 32'(busy), 32'd0);
        checkOutput({tag, "_freeze_after"}, 32'(freeze), 32'd0);
    endtask

    initial begin
        int b0;
        int n;
        logic [15:0] w;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_freeze", 32'(freeze), 32'd0);
        checkOutput("rst_valid", 32'(tx_valid), 32'd0);
        checkOutput("rst_data", 32'(tx_data), 32'd0);
        checkOutput("rst_rd_addr", 32'(rd_addr), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        rst = 1'b1;

        for (int a = 0; a < 2048; a++) begin
            wr_addr = 11'(a); wr_data = 16'(a) ^ 16'h5A5A; wren = 1'b1;
            wren_b = (a < 16); wr_addr_b = 4'(a); wr_data_b = 16'(a) ^ 16'h3C3C;
            @(posedge clk); #1;
        end
        wren = 1'b0; wren_b = 1'b0;

        $display("[TB] idle trigger pulses, then dump with trigger at 100");
        trigger = 1'b1;
        repeat (3) @(posedge clk);
        #1 trigger = 1'b0;
        checkOutput("idle_trigger_busy", 32'(busy), 32'd0);
        applyStimulus(100, 1'b0);
        waitDone("t1");

        $display("[TB] random ready dump");
        rand_ready = 1'b1;
        applyStimulus(100, 1'b0);
        waitDone("t2");
        rand_ready = 1'b0;

        $display("[TB] wrapping dump with retrigger in post window");
        applyStimulus(2040, 1'b1);
        waitDone("t3");

        $display("[TB] reset mid-dump and re-arm");
        applyStimulus(300, 1'b0);
        b0 = byte_cnt; n = 0;
        while (byte_cnt - b0 < 300 && n < 5000) begin
            @(posedge clk); #1 n++;
        end
        checkOutput("t5_bytes_before_reset", 32'(byte_cnt - b0 >= 300), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("t5_freeze", 32'(freeze), 32'd0);
        checkOutput("t5_valid", 32'(tx_valid), 32'd0);
        checkOutput("t5_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        exp_q.delete();
        applyStimulus(500, 1'b0);
        waitDone("t5");

        $display("[TB] POST_SAMPLES=0 build, trigger write at 7");
        start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        exp_b.push_back(8'hA5);
        for (int i = 0; i < 16; i++) begin
            w = 16'((8 + i) % 16) ^ 16'h3C3C;
            exp_b.push_back(w[15:8]);
            exp_b.push_back(w[7:0]);
        end
        checkOutput("b_freeze_before", 32'(freeze_b), 32'd0);
        trigger_b = 1'b1; wren_b = 1'b1; wr_addr_b = 4'd7; wr_data_b = 16'd7 ^ 16'h3C3C;
        @(posedge clk); #1 trigger_b = 1'b0; wren_b = 1'b0;
        checkOutput("b_freeze_next", 32'(freeze_b), 32'd1);
        n = 0;
        while (done_cnt_b == 0 && n < 500) begin
            @(posedge clk); #1 n++;
        end
        checkOutput("b_done_count", 32'(done_cnt_b), 32'd1);
        checkOutput("b_queue_left", 32'(exp_b.size()), 32'd0);
        checkOutput("b_busy_after", 32'(busy_b), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
